instr_encoder_loader: RTL

- Encoder counterpart of the processor's instruction decoder.
- Accepts decoded instruction fields over a valid/ready stream and assembles RV32I instruction words.
- Writes the words sequentially into the instruction memory write port, starting at a programmed base address.
- Used by the bench and the boot path to load programs before the pipeline is released from stall.

---
 rtl/instr_encoder_loader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//
// Purpose:
//   Encoder counterpart of the instruction decoder. Takes decoded instruction
//   fields over a valid/ready stream, assembles RV32I instruction words and
//   writes them sequentially into the instruction-memory write port, starting
//   at a programmed base address. Used to load programs before the pipeline
//   is released from stall.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse, latches base_addr/num_words
//                         (honoured only in IDLE or DONE)
//   base_addr, num_words  first write byte address, number of legal words
//   in_valid / in_ready   field-beat handshake
//   fmt, funct3, funct7_5,
//   rd, rs1, rs2, imm     decoded instruction fields of one beat
//   imem_we, imem_addr,
//   imem_wdata            instruction-memory write port
//   busy                  high while in LOAD
//   done                  one-cycle completion pulse
//   err_cnt               saturating count of dropped illegal beats
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    num_words,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          fmt,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    input  logic [4:0]          rd,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic signed [31:0]  imm,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    err_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] FMT_R     = 4'd0;
    localparam logic [3:0] FMT_I     = 4'd1;
    localparam logic [3:0] FMT_S     = 4'd2;
    localparam logic [3:0] FMT_LOAD  = 4'd3;
    localparam logic [3:0] FMT_B     = 4'd4;
    localparam logic [3:0] FMT_JAL   = 4'd5;
    localparam logic [3:0] FMT_JALR  = 4'd6;
    localparam logic [3:0] FMT_AUIPC = 4'd7;
    localparam logic [3:0] FMT_LUI   = 4'd8;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;

    logic              accept;
    logic              illegal;
    logic [31:0]       enc_word;

    // The two address LSBs are forced to zero; they are deliberately unused.
    logic              unused_base_lsb;
    assign unused_base_lsb = ^base_addr[1:0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [31:0] encode(
        input logic [3:0]  f,
        input logic [2:0]  f3,
        input logic        f75,
        input logic [4:0]  rd_v,
        input logic [4:0]  rs1_v,
        input logic [4:0]  rs2_v,
        input logic [31:0] im
    );
        logic [31:0] w;
        w = 32'h0;
        case (f)
            FMT_R:     w = {1'b0, f75, 5'b0, rs2_v, rs1_v, f3, rd_v, 7'b0110011};
            FMT_I: begin
                // Shift-immediates carry the SRAI select in bit 30 and only a
                // 5-bit shift amount.
                if (f3 == 3'b001 || f3 == 3'b101)
                    w = {1'b0, f75, 5'b0, im[4:0], rs1_v, f3, rd_v, 7'b0010011};
                else
                    w = {im[11:0], rs1_v, f3, rd_v, 7'b0010011};
            end
            FMT_S:     w = {im[11:5], rs2_v, rs1_v, f3, im[4:0], 7'b0100011};
            FMT_LOAD:  w = {im[11:0], rs1_v, f3, rd_v, 7'b0000011};
            FMT_B:     w = {im[12], im[10:5], rs2_v, rs1_v, f3, im[4:1], im[11], 7'b1100011};
            FMT_JAL:   w = {im[20], im[10:1], im[11], im[19:12], rd_v, 7'b1101111};
            FMT_JALR:  w = {im[11:0], rs1_v, 3'b000, rd_v, 7'b1100111};
            FMT_AUIPC: w = {im[31:12], rd_v, 7'b0010111};
            FMT_LUI:   w = {im[31:12], rd_v, 7'b0110111};
            default:   w = 32'h0;
        endcase
        return w;
    endfunction

    assign in_ready = (state_q == ST_LOAD) && (rem_q != '0);
    assign accept   = in_valid && in_ready;

    // Branch/jump targets must be halfword aligned; anything past LUI is
    // not a known format.
    assign illegal  = (fmt > FMT_LUI) ||
                      (((fmt == FMT_B) || (fmt == FMT_JAL)) && imm[0]);

    assign enc_word = encode(fmt, funct3, funct7_5, rd, rs1, rs2, imm);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    ptr_d = {base_addr[ADDR_W-1:2], 2'b00};
                    rem_d = num_words;
                    err_d = '0;
                    if (num_words == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                // remaining hits zero on the cycle the last write is visible;
                // completion follows one cycle later.
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (accept) begin
                    if (illegal) begin
                        err_d = sat_inc(err_q);
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = enc_word;
                        ptr_d   = ptr_q + ADDR_W'(4);
                        rem_d   = rem_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            err_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q == ST_LOAD);
    assign done       = done_q;
    assign err_cnt    = err_q;

endmodule
